// File: rtl/led_pkg.sv
// rtl/led_pkg.sv - shared mode and direction encodings for the LED scanner family
package led_pkg;

    localparam logic [1:0] MODE_BOUNCE = 2'd0;
    localparam logic [1:0] MODE_WRAP   = 2'd1;
    localparam logic [1:0] MODE_FILL   = 2'd2;
    localparam logic [1:0] MODE_HOLD   = 2'd3;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    // Position register width; a single-LED bar still needs one bit.
    function automatic int pos_width(input int n_leds);
        return (n_leds > 1) ? $clog2(n_leds) : 1;
    endfunction

endpackage

// File: rtl/led_scanner_tick_gen.sv
// rtl/led_scanner_tick_gen.sv - programmable step prescaler, one TICK every DIV+1 enabled cycles
module tick_gen
    import led_pkg::*;
#(
    parameter int DIV_W = 24
) (
    input  logic             CLK,
    input  logic             RSTn,
    input  logic             ENABLE,
    input  logic [DIV_W-1:0] DIV,
    output logic             TICK
);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;
    logic             tick;

    // >= rather than == so a DIV lowered below cnt ticks at once instead of wrapping.
    always_comb begin
        tick  = ENABLE && (cnt_q >= DIV);
        cnt_d = cnt_q;
        if (ENABLE) begin
            cnt_d = tick ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign TICK = tick;

endmodule

// File: rtl/led_scanner.sv
// rtl/led_scanner.sv - N-wide LED bar animator: bounce, wrap, fill-bar and hold at a prescaled step rate
module led_scanner
    import led_pkg::*;
#(
    parameter  int N_LEDS = 8,
    parameter  int DIV_W  = 24,
    localparam int POS_W  = (N_LEDS > 1) ? $clog2(N_LEDS) : 1
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              ENABLE,
    input  logic [1:0]        MODE,
    input  logic [DIV_W-1:0]  DIV,
    output logic [N_LEDS-1:0] LEDG,
    output logic [POS_W-1:0]  POS,
    output logic              STEP
);

    localparam logic [POS_W-1:0] LAST = POS_W'(N_LEDS - 1);

    logic             tick;
    logic [POS_W-1:0] pos_q, pos_d;
    logic             dir_q, dir_d;
    logic [1:0]       mode_q, mode_d;
    logic             step_q;
    logic [N_LEDS-1:0] ledg;

    tick_gen #(
        .DIV_W (DIV_W)
    ) u_tick_gen (
        .CLK    (CLK),
        .RSTn   (RSTn),
        .ENABLE (ENABLE),
        .DIV    (DIV),
        .TICK   (tick)
    );

    // Motion follows the mode sampled on this tick, not the previous one.
    always_comb begin
        pos_d  = pos_q;
        dir_d  = dir_q;
        mode_d = mode_q;
        if (tick) begin
            mode_d = MODE;
            case (MODE)
                MODE_WRAP: begin
                    dir_d = DIR_UP;
                    pos_d = (pos_q == LAST) ? '0 : pos_q + 1'b1;
                end
                MODE_HOLD: begin
                end
                default: begin
                    // A one-LED bar has nowhere to bounce to.
                    if (N_LEDS > 1) begin
                        if (dir_q == DIR_UP) begin
                            if (pos_q == LAST) begin
                                dir_d = DIR_DOWN;
                                pos_d = pos_q - 1'b1;
                            end else begin
                                pos_d = pos_q + 1'b1;
                            end
                        end else begin
                            if (pos_q == '0) begin
                                dir_d = DIR_UP;
                                pos_d = pos_q + 1'b1;
                            end else begin
                                pos_d = pos_q - 1'b1;
                            end
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            pos_q  <= '0;
            dir_q  <= DIR_UP;
            mode_q <= MODE_BOUNCE;
            step_q <= 1'b0;
        end else begin
            pos_q  <= pos_d;
            dir_q  <= dir_d;
            mode_q <= mode_d;
            step_q <= tick;
        end
    end

    // Decoded only from registers so MODE edges between ticks never glitch the bar.
    always_comb begin
        ledg = '0;
        for (int i = 0; i < N_LEDS; i++) begin
            if (mode_q == MODE_FILL) begin
                ledg[i] = (POS_W'(i) <= pos_q);
            end else begin
                ledg[i] = (POS_W'(i) == pos_q);
            end
        end
    end

    assign LEDG = ledg;
    assign POS  = pos_q;
    assign STEP = step_q;

endmodule

// File: tb/tb_led_scanner.sv
// tb/tb_led_scanner.sv - scoreboard bench for led_scanner at N_LEDS = 8, 2 and 1
module tb_led_scanner;

    logic        clk;
    logic        rstn;
    logic        en;
    logic [1:0]  mode;
    logic [23:0] div;

    logic [7:0]  ledg8;
    logic [2:0]  pos8;
    logic        step8;
    logic [1:0]  ledg2;
    logic [0:0]  pos2;
    logic        step2;
    logic [0:0]  ledg1;
    logic [0:0]  pos1;
    logic        step1;

    led_scanner #(.N_LEDS(8), .DIV_W(24)) dut8 (
        .CLK(clk), .RSTn(rstn), .ENABLE(en), .MODE(mode), .DIV(div),
        .LEDG(ledg8), .POS(pos8), .STEP(step8)
    );
    led_scanner #(.N_LEDS(2), .DIV_W(24)) dut2 (
        .CLK(clk), .RSTn(rstn), .ENABLE(en), .MODE(mode), .DIV(div),
        .LEDG(ledg2), .POS(pos2), .STEP(step2)
    );
    led_scanner #(.N_LEDS(1), .DIV_W(24)) dut1 (
        .CLK(clk), .RSTn(rstn), .ENABLE(en), .MODE(mode), .DIV(div),
        .LEDG(ledg1), .POS(pos1), .STEP(step1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] e8;
        logic [63:0] e2;
        logic [63:0] e1;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    int   nl[3] = '{8, 2, 1};
    int   m_cnt;
    int   m_mode;
    int   m_step;
    int   m_pos[3];
    int   m_dir[3];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model_ledg(input int pos, input int md);
        if (md == 2) return (64'd1 << (pos + 1)) - 64'd1;
        return 64'd1 << pos;
    endfunction

    function automatic logic [63:0] pack(input logic [63:0] l, input int p, input int s);
        return (l << 16) | (64'(p) << 8) | 64'(s);
    endfunction

    task automatic model_step();
        int tick;
        if (!rstn) begin
            m_cnt  = 0;
            m_mode = 0;
            m_step = 0;
            for (int b = 0; b < 3; b++) begin
                m_pos[b] = 0;
                m_dir[b] = 1;
            end
        end else begin
            tick = (en && (m_cnt >= int'(div))) ? 1 : 0;
            if (en) m_cnt = tick ? 0 : m_cnt + 1;
            m_step = tick;
            if (tick != 0) begin
                m_mode = int'(mode);
                for (int b = 0; b < 3; b++) begin
                    if (m_mode == 1) begin
                        m_dir[b] = 1;
                        m_pos[b] = (m_pos[b] + 1) % nl[b];
                    end else if (m_mode != 3 && nl[b] > 1) begin
                        if (m_pos[b] + m_dir[b] < 0 || m_pos[b] + m_dir[b] > nl[b] - 1)
                            m_dir[b] = -m_dir[b];
                        m_pos[b] = m_pos[b] + m_dir[b];
                    end
                end
            end
        end
    endtask

    task automatic cycle();
        exp_t e;
        exp_t got;
        @(posedge clk);
        model_step();
        e.e8 = pack(model_ledg(m_pos[0], m_mode), m_pos[0], m_step);
        e.e2 = pack(model_ledg(m_pos[1], m_mode), m_pos[1], m_step);
        e.e1 = pack(model_ledg(m_pos[2], m_mode), m_pos[2], m_step);
        sb.push_back(e);
        @(negedge clk);
        got = sb.pop_front();
        check("sb_n8", pack(64'(ledg8), int'(pos8), int'(step8)), got.e8);
        check("sb_n2", pack(64'(ledg2), int'(pos2), int'(step2)), got.e2);
        check("sb_n1", pack(64'(ledg1), int'(pos1), int'(step1)), got.e1);
    endtask

    logic [7:0] bseq[14] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
                             8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02};
    logic [7:0] fseq[16] = '{8'h3F, 8'h1F, 8'h0F, 8'h07, 8'h03, 8'h01, 8'h03, 8'h07,
                             8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF, 8'h7F, 8'h3F, 8'h1F};

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int steps;
        int found;
        int n;

        rstn = 1'b0;
        en   = 1'b0;
        mode = 2'd0;
        div  = 24'd0;
        repeat (2) cycle();
        check("rst_ledg", 64'(ledg8), 64'h01);
        check("rst_pos", 64'(pos8), 64'd0);
        check("rst_step", 64'(step8), 64'd0);

        rstn = 1'b1;
        en   = 1'b1;
        for (int k = 0; k < 28; k++) begin
            cycle();
            check("bounce_ledg", 64'(ledg8), 64'(bseq[(k + 1) % 14]));
            check("bounce_step", 64'(step8), 64'd1);
        end

        div   = 24'd2;
        steps = 0;
        for (int k = 0; k < 12; k++) begin
            cycle();
            steps += int'(step8);
        end
        check("div2_steps", 64'(steps), 64'd4);

        mode = 2'd1;
        div  = 24'd0;
        repeat (20) cycle();
        found = 0;
        for (int k = 0; k < 16 && found == 0; k++) begin
            cycle();
            if (pos8 == 3'd7) found = 1;
        end
        check("wrap_reach7", 64'(found), 64'd1);
        mode = 2'd0;
        cycle();
        check("wrap_to_bounce", 64'(ledg8), 64'h40);

        mode = 2'd2;
        for (int k = 0; k < 16; k++) begin
            cycle();
            check("fill_ledg", 64'(ledg8), 64'(fseq[k]));
        end

        mode = 2'd0;
        div  = 24'd3;
        cycle();
        check("cnt_one", 64'(dut8.u_tick_gen.cnt_q), 64'd1);
        en = 1'b0;
        for (int k = 0; k < 10; k++) begin
            cycle();
            check("frozen_step", 64'(step8), 64'd0);
            check("frozen_cnt", 64'(dut8.u_tick_gen.cnt_q), 64'd1);
        end
        en    = 1'b1;
        n     = 0;
        found = 0;
        for (int k = 0; k < 10 && found == 0; k++) begin
            cycle();
            n++;
            if (step8) found = 1;
        end
        check("resume_cycles", 64'(n), 64'd3);

        div = 24'd20;
        repeat (15) cycle();
        check("cnt15", 64'(dut8.u_tick_gen.cnt_q), 64'd15);
        div = 24'd2;
        cycle();
        check("div_drop_tick", 64'(step8), 64'd1);

        mode  = 2'd2;
        div   = 24'd0;
        found = 0;
        for (int k = 0; k < 20 && found == 0; k++) begin
            cycle();
            if (pos8 == 3'd5) found = 1;
        end
        check("fill_reach5", 64'(found), 64'd1);
        check("fill_pos5_ledg", 64'(ledg8), 64'h3F);
        rstn = 1'b0;
        cycle();
        check("midrst_ledg", 64'(ledg8), 64'h01);
        check("midrst_pos", 64'(pos8), 64'd0);
        check("midrst_step", 64'(step8), 64'd0);
        check("midrst_mode", 64'(dut8.mode_q), 64'd0);
        rstn = 1'b1;

        mode = 2'd3;
        for (int k = 0; k < 6; k++) begin
            cycle();
            check("hold_step", 64'(step8), 64'd1);
            check("hold_ledg", 64'(ledg8), 64'h01);
            check("n1_ledg", 64'(ledg1), 64'd1);
        end

        mode = 2'd0;
        for (int k = 0; k < 8; k++) begin
            cycle();
            check("n2_bounce", 64'(ledg2), (k % 2 == 0) ? 64'h2 : 64'h1);
        end

        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
